uart_wb_if: RTL
===============

Name: uart_wb_if

Overview:
- Wishbone classic slave front end for the UART; sits directly upstream of the register file.
- Converts a Wishbone cycle into a latched address/data plus exactly one single-cycle read or write strobe toward the register file.
- Captures the register file's combinational read data and returns it with a one-cycle ack.
- Guarantees one register access per bus transaction, so reads with side effects (RX FIFO pop, LSR/MSR/IIR clear) fire once.

Parameters:
ADDR_W, 3, register address width; equals UART_ADDR_WIDTH from the shared package.

Ports:
clk  input  1  system clock
wb_rst_i  input  1  asynchronous, active-high reset
wb_cyc_i  input  1  Wishbone cycle
wb_stb_i  input  1  Wishbone strobe
wb_we_i  input  1  Wishbone write enable
wb_adr_i  input  ADDR_W  Wishbone address
wb_dat_i  input  DW  Wishbone write data; DW is 8, or 32 with the optional feature
wb_sel_i  input  4  byte selects; present only with the optional feature
wb_dat_o  output  DW  registered read data
wb_ack_o  output  1  transfer acknowledge
reg_addr_o  output  ADDR_W  latched register address
reg_dat_o  output  8  latched write byte
reg_we_o  output  1  one-cycle register write strobe
reg_re_o  output  1  one-cycle register read strobe
reg_dat_i  input  8  combinational read data from the register file

Behaviour:
- Reset is asynchronous on wb_rst_i, active-high; clock is clk.
- Reset values: state IDLE; wb_ack_o 0; reg_we_o 0; reg_re_o 0; wb_dat_o 0; reg_addr_o 0; reg_dat_o 0.
- State machine has four states: IDLE, STROBE, ACK, WAIT_END.
- IDLE:
  - On cyc&stb, latch the address, write data and we.
  - Go to STROBE.
- STROBE:
  - Assert reg_we_o if the latched we is 1, otherwise assert reg_re_o. The strobe lasts exactly one cycle.
  - On a read, wb_dat_o captures reg_dat_i on the closing edge. This captures the pre-pop value.
  - Go to ACK.
  - The access is committed once STROBE is entered, even if cyc drops.
- ACK:
  - If cyc is still 1, wb_ack_o=1 for this single cycle. Otherwise wb_ack_o stays 0.
  - Go to WAIT_END.
- WAIT_END:
  - Stay while cyc&stb is held.
  - Return to IDLE when cyc&stb is 0.
  - This prevents a second access from a stb that is held past ack.
- Latency: request sampled at edge 0, strobe during cycle 1, ack during cycle 2.
- Back-to-back transfers take a minimum of 4 cycles.
- reg_addr_o and reg_dat_o hold their value until the next request is latched.
- wb_dat_o holds its value after a write and updates only on reads.
- reg_we_o and reg_re_o are never asserted simultaneously.
- No strobe is ever issued outside STROBE.
- stb without cyc is ignored.
- Reset mid-transaction forces IDLE immediately; a pending strobe or ack is dropped.

Optional Feature:
Macro UART_WB_BUS32_EN: 32-bit data bus.
- With the macro:
  - DW=32 and wb_sel_i is present.
  - The low two bits of wb_adr_i are ignored. The byte lane comes from a one-hot wb_sel_i: sel 0001 gives lane 0 (data bits 7:0), 0010 gives lane 1 (bits 15:8), and so on.
  - reg_addr_o is {wb_adr_i[ADDR_W-1:2], lane}. reg_dat_o is the selected write-data byte.
  - Read data is placed in the selected lane; all other lanes are 0.
  - A wb_sel_i that is not one-hot (including 0000) produces no strobe. The transaction still completes with ack and wb_dat_o=0.
- Without the macro:
  - DW=8 and there is no wb_sel_i.
  - The address passes through unchanged.

Decomposition:
- Shared package (the existing uart_defines): UART_ADDR_WIDTH, the register address constants, and the state encodings IF_IDLE, IF_STROBE, IF_ACK, IF_WAIT_END.
- No sub-module: a single flat module.
- Lane decode and read-data placement sit inline under the macro.

Test Plan:
1. Write: write 8'hA5 to address 3 (LCR) with stb held 3 cycles → reg_we_o high exactly one cycle at cycle 1, reg_addr_o=3, reg_dat_o=A5, wb_ack_o at cycle 2, no second strobe.
2. Read: read address 5 with reg_dat_i=8'h60 during STROBE, changing to 8'h00 afterwards → wb_dat_o=60 at ack, single reg_re_o pulse.
3. Held stb: keep stb=1 for 6 cycles after ack → stays in WAIT_END, zero additional strobes; drop stb, then a new read is accepted 1 cycle later.
4. Abort: drop cyc during STROBE → the strobe still fires once, wb_ack_o stays 0, FSM returns to IDLE.
5. Reset: assert wb_rst_i during STROBE → reg_re_o and wb_ack_o go to 0 asynchronously; all outputs hold their reset values.
6. 32-bit mode (UART_WB_BUS32_EN): write with wb_sel_i=0100 and wb_dat_i=32'h00C30000 → reg_addr_o low bits=2, reg_dat_o=C3. Then wb_sel_i=0110 → ack with no strobe and wb_dat_o=0.

Source files
------------

// File: rtl/uart_defines.sv
// Shared UART definitions: register map, Wishbone interface FSM encodings and bus width.
// UART_WB_BUS32_EN selects the 32-bit Wishbone data bus with byte-lane selects.
package uart_defines;

  localparam int UART_ADDR_WIDTH = 3;

  localparam logic [UART_ADDR_WIDTH-1:0] UART_REG_RB_TR = 3'd0;
  localparam logic [UART_ADDR_WIDTH-1:0] UART_REG_IE    = 3'd1;
  localparam logic [UART_ADDR_WIDTH-1:0] UART_REG_II_FC = 3'd2;
  localparam logic [UART_ADDR_WIDTH-1:0] UART_REG_LC    = 3'd3;
  localparam logic [UART_ADDR_WIDTH-1:0] UART_REG_MC    = 3'd4;
  localparam logic [UART_ADDR_WIDTH-1:0] UART_REG_LS    = 3'd5;
  localparam logic [UART_ADDR_WIDTH-1:0] UART_REG_MS    = 3'd6;
  localparam logic [UART_ADDR_WIDTH-1:0] UART_REG_SR    = 3'd7;

`ifdef UART_WB_BUS32_EN
  localparam int UART_WB_DW = 32;
`else
  localparam int UART_WB_DW = 8;
`endif

  typedef enum logic [1:0] {
    IF_IDLE     = 2'd0,
    IF_STROBE   = 2'd1,
    IF_ACK      = 2'd2,
    IF_WAIT_END = 2'd3
  } if_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] lane;
  } lane_sel_t;

  // Only a one-hot select names a byte lane; anything else is rejected.
  function automatic lane_sel_t sel_decode(input logic [3:0] sel);
    lane_sel_t r;
    r = '0;
    case (sel)
      4'b0001: r = '{valid: 1'b1, lane: 2'd0};
      4'b0010: r = '{valid: 1'b1, lane: 2'd1};
      4'b0100: r = '{valid: 1'b1, lane: 2'd2};
      4'b1000: r = '{valid: 1'b1, lane: 2'd3};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_wb_if.sv
// Wishbone classic slave front end: one latched register access and one ack per bus cycle.
// Define UART_WB_BUS32_EN for the 32-bit data bus with one-hot wb_sel_i lane selection.
module uart_wb_if
  import uart_defines::*;
#(
  parameter int ADDR_W = UART_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_W-1:0]     wb_adr_i,
  input  logic [UART_WB_DW-1:0] wb_dat_i,
`ifdef UART_WB_BUS32_EN
  input  logic [3:0]            wb_sel_i,
`endif
  output logic [UART_WB_DW-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic [ADDR_W-1:0]     reg_addr_o,
  output logic [7:0]            reg_dat_o,
  output logic                  reg_we_o,
  output logic                  reg_re_o,
  input  logic [7:0]            reg_dat_i
);

  if_state_t state, state_next;
  logic      req;
  logic      lat_we;
  logic      lat_ok;

  assign req = wb_cyc_i && wb_stb_i;

`ifdef UART_WB_BUS32_EN
  lane_sel_t req_lane;
  assign req_lane = sel_decode(wb_sel_i);
`endif

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IF_IDLE;
    else          state <= state_next;
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_next = state;
    reg_we_o   = 1'b0;
    reg_re_o   = 1'b0;
    wb_ack_o   = 1'b0;
    case (state)
      IF_IDLE: if (req) state_next = IF_STROBE;
      IF_STROBE: begin
        // Committed once entered: the strobe fires even if the master abandons the cycle.
        reg_we_o   = lat_ok && lat_we;
        reg_re_o   = lat_ok && !lat_we;
        state_next = IF_ACK;
      end
      IF_ACK: begin
        wb_ack_o   = wb_cyc_i;
        state_next = IF_WAIT_END;
      end
      IF_WAIT_END: if (!req) state_next = IF_IDLE;
      default: state_next = IF_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lat_we     <= 1'b0;
      lat_ok     <= 1'b0;
      reg_addr_o <= '0;
      reg_dat_o  <= '0;
      wb_dat_o   <= '0;
    end else begin
      if (state == IF_IDLE && req) begin
        lat_we <= wb_we_i;
`ifdef UART_WB_BUS32_EN
        lat_ok     <= req_lane.valid;
        reg_addr_o <= {wb_adr_i[ADDR_W-1:2], req_lane.lane};
        reg_dat_o  <= wb_dat_i[req_lane.lane*8 +: 8];
`else
        lat_ok     <= 1'b1;
        reg_addr_o <= wb_adr_i;
        reg_dat_o  <= wb_dat_i;
`endif
      end
      // Read data is sampled on the edge closing STROBE, i.e. before any pop takes effect.
      if (state == IF_STROBE) begin
`ifdef UART_WB_BUS32_EN
        if (!lat_ok)      wb_dat_o <= '0;
        else if (!lat_we) wb_dat_o <= 32'(reg_dat_i) << {reg_addr_o[1:0], 3'b000};
`else
        if (!lat_we) wb_dat_o <= reg_dat_i;
`endif
      end
    end
  end

endmodule
